// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and MDR, sharing one memory port.
// Optional performance counters are compiled in with `define RISCV_SEQ_PERF_COUNTERS_EN.
module riscv_multicycle_sequencer #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    output logic [31:0] load_data,
    output logic        reg_write_commit,
    output logic        instr_retired,
    output logic        misalign_flag,
    output logic [2:0]  state_o
`ifdef RISCV_SEQ_PERF_COUNTERS_EN
    ,
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_retired,
    output logic [31:0] perf_mem_stalls
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req_raw;
    logic        we_raw;
    logic        redirect;
    logic        target_misaligned;
    logic [31:0] pc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = mem_ready ? DECODE : FETCH;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = (dec_mem_read || dec_mem_write) ? MEM : WB;
            MEM:     state_next = mem_ready ? WB : MEM;
            WB:      state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        req_raw          = 1'b0;
        we_raw           = 1'b0;
        mem_addr_sel     = 1'b0;
        reg_write_commit = 1'b0;
        instr_retired    = 1'b0;
        misalign_flag    = 1'b0;
        case (state)
            FETCH: begin
                req_raw = 1'b1;
            end
            MEM: begin
                req_raw      = 1'b1;
                we_raw       = dec_mem_write;
                mem_addr_sel = 1'b1;
            end
            WB: begin
                reg_write_commit = dec_reg_write;
                instr_retired    = 1'b1;
                misalign_flag    = redirect && target_misaligned;
            end
            default: begin
                req_raw = 1'b0;
            end
        endcase
    end

    // Reset must kill an in-flight access at once, not at the next edge.
    assign mem_req = req_raw && !rst;
    assign mem_we  = we_raw && !rst;

    assign redirect          = dec_jump || (dec_branch && branch_taken);
    assign target_misaligned = (target_addr[1:0] != 2'b00);
    assign pc_next           = redirect ? (target_addr & ADDR_ALIGN_MASK) : (pc + 32'd4);
    assign state_o           = state;

    // Each architectural register is written in exactly one state, so intents act once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            load_data   <= 32'h0000_0000;
        end else begin
            if (state == FETCH && mem_ready) begin
                instruction <= mem_rdata;
            end
            if (state == MEM && mem_ready && dec_mem_read && !dec_mem_write) begin
                load_data <= mem_rdata;
            end
            if (state == WB) begin
                pc <= pc_next;
            end
        end
    end

`ifdef RISCV_SEQ_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles     <= 64'd0;
            perf_retired    <= 64'd0;
            perf_mem_stalls <= 32'd0;
        end else begin
            perf_cycles <= perf_cycles + 64'd1;
            if (instr_retired) begin
                perf_retired <= perf_retired + 64'd1;
            end
            if (mem_req && !mem_ready) begin
                perf_mem_stalls <= perf_mem_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// Self-checking bench for riscv_multicycle_sequencer: directed test-plan steps then random instructions,
// each checked cycle by cycle against a per-instruction timeline model.
module tb_riscv_multicycle_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4, K_RDWR = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instruction, pc, load_data;
    logic        dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0;
    logic        dec_branch = 1'b0, dec_jump = 1'b0, branch_taken = 1'b0;
    logic [31:0] target_addr = 32'h0;
    logic        reg_write_commit, instr_retired, misalign_flag;
    logic [2:0]  state_o;
`ifdef RISCV_SEQ_PERF_COUNTERS_EN
    logic [63:0] perf_cycles, perf_retired;
    logic [31:0] perf_mem_stalls;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_pc, exp_instr, exp_load;

    riscv_multicycle_sequencer #(
        .RESET_PC        (RESET_PC),
        .ADDR_ALIGN_MASK (MASK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr_sel     (mem_addr_sel),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .instruction      (instruction),
        .pc               (pc),
        .dec_mem_read     (dec_mem_read),
        .dec_mem_write    (dec_mem_write),
        .dec_reg_write    (dec_reg_write),
        .dec_branch       (dec_branch),
        .dec_jump         (dec_jump),
        .branch_taken     (branch_taken),
        .target_addr      (target_addr),
        .load_data        (load_data),
        .reg_write_commit (reg_write_commit),
        .instr_retired    (instr_retired),
        .misalign_flag    (misalign_flag),
        .state_o          (state_o)
`ifdef RISCV_SEQ_PERF_COUNTERS_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_retired     (perf_retired),
        .perf_mem_stalls  (perf_mem_stalls)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from the start of FETCH; abort_cycle >= 0 fires reset in that cycle.
    task automatic applyStimulus(input int kind, input int fw, input int mw,
                                 input logic [31:0] iword, input logic [31:0] ldword,
                                 input logic [31:0] tgt, input logic taken, input int abort_cycle);
        logic        rd, wr, rw, br, jp, is_mem, redir, rdy, req;
        int          total, st;
        logic [31:0] nxt;
        rd = (kind == K_LOAD) || (kind == K_RDWR);
        wr = (kind == K_STORE) || (kind == K_RDWR);
        rw = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP);
        br = (kind == K_BRANCH);
        jp = (kind == K_JUMP);
        is_mem = rd || wr;
        redir  = jp || (br && taken);
        nxt    = redir ? (tgt & MASK) : (exp_pc + 32'd4);
        total  = 4 + fw + (is_mem ? mw + 1 : 0);
        dec_mem_read  = rd;
        dec_mem_write = wr;
        dec_reg_write = rw;
        dec_branch    = br;
        dec_jump      = jp;
        branch_taken  = taken;
        target_addr   = tgt;
        for (int c = 0; c < total; c++) begin
            rdy = 1'b0;
            if (c <= fw) begin
                st = 0; rdy = (c == fw);
            end else if (c == fw + 1) begin
                st = 1;
            end else if (c == fw + 2) begin
                st = 2;
            end else if (is_mem && c <= fw + 3 + mw) begin
                st = 3; rdy = (c == fw + 3 + mw);
            end else begin
                st = 4;
            end
            req = (st == 0) || (st == 3);
            mem_ready = rdy ? 1'b1 : (req ? 1'b0 : 1'($urandom_range(0, 1)));
            mem_rdata = rdy ? ((st == 0) ? iword : ldword) : $urandom;
            #1;
            checkOutput("state", {29'b0, state_o}, st);
            checkOutput("mem_req", {31'b0, mem_req}, {31'b0, req});
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, (st == 3) && wr});
            if (req) checkOutput("mem_addr_sel", {31'b0, mem_addr_sel}, {31'b0, st == 3});
            checkOutput("reg_write_commit", {31'b0, reg_write_commit}, {31'b0, (st == 4) && rw});
            checkOutput("instr_retired", {31'b0, instr_retired}, {31'b0, st == 4});
            checkOutput("misalign_flag", {31'b0, misalign_flag},
                        {31'b0, (st == 4) && redir && (tgt[1:0] != 2'b00)});
            checkOutput("pc", pc, exp_pc);
            checkOutput("instruction", instruction, exp_instr);
            checkOutput("load_data", load_data, exp_load);
            if (c == abort_cycle) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
                checkOutput("rst_state", {29'b0, state_o}, 32'd0);
                checkOutput("rst_pc", pc, RESET_PC);
                checkOutput("rst_commit", {31'b0, reg_write_commit | instr_retired}, 32'd0);
                mem_ready = 1'b0;
                @(negedge clk);
                checkOutput("rst_hold_instr", instruction, NOP);
                checkOutput("rst_hold_load", load_data, 32'd0);
                rst = 1'b0;
                exp_pc = RESET_PC; exp_instr = NOP; exp_load = 32'd0;
                return;
            end
            if (st == 0 && rdy) exp_instr = iword;
            if (st == 3 && rdy && rd && !wr) exp_load = ldword;
            if (st == 4) exp_pc = nxt;
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        int kind;
        logic [31:0] tgt;
        exp_pc = RESET_PC; exp_instr = NOP; exp_load = 32'd0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_state", {29'b0, state_o}, 32'd0);
        checkOutput("reset_pc", pc, RESET_PC);
        checkOutput("reset_instr", instruction, NOP);
        checkOutput("reset_load", load_data, 32'd0);
        checkOutput("reset_pulses", {29'b0, reg_write_commit, instr_retired, misalign_flag}, 32'd0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(K_ALU,    0, 0, 32'h0050_0093, 32'h0, 32'h0, 1'b0, -1);
        applyStimulus(K_LOAD,   0, 3, 32'h0000_2083, 32'hDEAD_BEEF, 32'h0, 1'b0, -1);
        applyStimulus(K_STORE,  1, 0, 32'h0010_2023, 32'h1234_5678, 32'h0, 1'b0, -1);
        applyStimulus(K_BRANCH, 0, 0, 32'h0000_0063, 32'h0, 32'h0000_0200, 1'b1, -1);
        applyStimulus(K_BRANCH, 0, 0, 32'h0000_0063, 32'h0, 32'h0000_0300, 1'b0, -1);
        applyStimulus(K_JUMP,   0, 0, 32'h0000_006F, 32'h0, 32'h0000_0203, 1'b0, -1);
        applyStimulus(K_ALU,    0, 0, 32'h0000_0013, 32'h0, 32'h0000_0400, 1'b1, -1);
        applyStimulus(K_JUMP,   2, 0, 32'h0000_006F, 32'h0, 32'hFFFF_FFFC, 1'b0, -1);
        applyStimulus(K_ALU,    0, 0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, -1);
        applyStimulus(K_RDWR,   0, 1, 32'h0000_0003, 32'hCAFE_F00D, 32'h0, 1'b0, -1);
        applyStimulus(K_LOAD,   0, 6, 32'h0000_2083, 32'h0BAD_0BAD, 32'h0, 1'b0, 5);
        applyStimulus(K_ALU,    0, 0, 32'h0050_0093, 32'h0, 32'h0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            tgt  = $urandom;
            applyStimulus(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
                          tgt, 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_sequencer.md
Name: riscv_multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the single-issue RISC-V core.
- Owns the PC and instruction register and feeds the IR to the instruction decoder.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, time-sharing one memory port between instruction fetch and load/store.
- Qualifies the decoder's register-write and PC-update intents so each takes effect exactly once per instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_ALIGN_MASK, 32'hFFFF_FFFC, mask applied to every redirect target.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr_sel  out  1  0 = address is pc, 1 = address is ALU result
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1
- instruction  out  32  instruction register, to the decoder
- pc  out  32  current PC, to decoder and ALU
- dec_mem_read  in  1  decoder load intent
- dec_mem_write  in  1  decoder store intent
- dec_reg_write  in  1  decoder register-write intent
- dec_branch  in  1  conditional-branch instruction
- dec_jump  in  1  JAL/JALR instruction
- branch_taken  in  1  ALU compare result
- target_addr  in  32  computed branch/jump target
- load_data  out  32  latched load data (MDR)
- reg_write_commit  out  1  register-file write enable pulse
- instr_retired  out  1  one-cycle pulse per completed instruction
- misalign_flag  out  1  one-cycle pulse when a redirect target had bits[1:0] != 0
- state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (asynchronous, active-high; immediate, even mid-access):
  - state=FETCH, pc=RESET_PC.
  - instruction=32'h0000_0013 (NOP), load_data=0.
  - All pulse outputs are 0.
  - mem_req is reasserted in the first cycle after rst deasserts.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5..7 go to FETCH on the next clock.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr_sel=0.
  - Holds until mem_ready=1, then latches instruction<=mem_rdata and goes to DECODE.
- DECODE: one cycle, no memory request; decoder settles. Goes to EXEC.
- EXEC: one cycle; ALU settles.
  - dec_mem_read or dec_mem_write -> MEM.
  - Otherwise -> WB.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=dec_mem_write.
  - Holds until mem_ready=1.
  - On ready with a read, latches load_data<=mem_rdata. Goes to WB.
  - If read and write are both asserted, the write wins: mem_we=1 and load_data is unchanged.
- Request rules:
  - Once mem_req=1, it and the address select stay stable until mem_ready. No abort except reset.
  - mem_ready while mem_req=0 is ignored.
- WB: one cycle.
  - reg_write_commit=dec_reg_write.
  - instr_retired=1.
  - PC update, then -> FETCH.
- PC update in WB:
  - redirect = dec_jump | (dec_branch & branch_taken).
  - With redirect: pc<=target_addr & ADDR_ALIGN_MASK, and misalign_flag=1 if target_addr[1:0] != 0.
  - Without redirect: pc<=pc+32'd4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  - branch_taken is ignored when dec_branch=0.
- Latency:
  - ALU instruction with zero-wait memory: 4 cycles.
  - Load/store with zero-wait memory: 5 cycles.
  - Each memory wait cycle adds 1.
- Pulses: reg_write_commit, instr_retired and misalign_flag are only ever high in WB, and for exactly one cycle.

Optional Feature:
- Macro: RISCV_SEQ_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_cycles[63:0] (increments every clock out of reset) and perf_retired[63:0] (increments on instr_retired).
  - Adds perf_mem_stalls[31:0], which increments each cycle mem_req=1 and mem_ready=0.
  - All counters reset to 0 and wrap silently.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, then release; memory returns ADDI (0x00500093) with zero wait -> FETCH addr_sel=0 with pc=0x100; WB at cycle 4 pulses reg_write_commit and instr_retired; pc=0x104.
- Load, memory ready after 3 wait cycles in MEM, mem_rdata=0xDEADBEEF -> mem_req held with mem_addr_sel=1 for 4 cycles; load_data=0xDEADBEEF; commit in WB; total 8 cycles.
- Store with dec_mem_write=1 and dec_reg_write=0 -> mem_we=1 only in MEM; reg_write_commit stays 0; pc+=4.
- Branch with branch_taken=1, target 0x200 -> pc=0x200. Same with branch_taken=0 -> pc=pc+4. Jump to target 0x203 -> pc=0x200 and misalign_flag pulses.
- pc=0xFFFF_FFFC, non-branch instruction -> pc=0x0000_0000 after WB.
- Assert rst during a MEM wait -> mem_req drops immediately; state=FETCH and pc=RESET_PC; no commit pulse; clean refetch after release.
